data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Arbitrates the single-port synchronous data memory between the pipeline MEM stage (CPU) and the image loader/DMA.
- Sits between the MEM stage, the loader, and the data RAM. Drives the RAM port and back-pressures the pipeline through cpu_stall, which the hazard unit ORs into its stall.
- CPU has priority. A starvation counter and a locked-burst mode let the loader move blocks without losing a word.

Parameters:
- RW, 24, data word width (matches register width)
- AW, 16, memory word-address width
- MAX_WAIT, 8, consecutive denied DMA cycles before DMA is forced to win
- MAX_BURST, 64, maximum consecutive grants in one locked DMA burst

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  MEM stage requests an access this cycle
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  RW  CPU write data
- cpu_stall  out  1  CPU lost arbitration; pipeline must hold MEM stage
- cpu_rvalid  out  1  cpu_rdata valid (read accepted previous cycle)
- cpu_rdata  out  RW  CPU read data
- dma_req  in  1  loader requests an access
- dma_lock  in  1  loader requests a locked burst
- dma_we  in  1  1=write, 0=read
- dma_addr  in  AW  loader word address
- dma_wdata  in  RW  loader write data
- dma_gnt  out  1  loader access accepted this cycle
- dma_rvalid  out  1  dma_rdata valid
- dma_rdata  out  RW  loader read data
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  RW  RAM write data
- mem_rdata  in  RW  RAM read data, valid the cycle after the address

Behaviour:
- Grant is combinational in cycle t. The winner's we/addr/wdata drive mem_* with mem_en=1. With no winner: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
- Read latency is 1 cycle. The owner register (NONE/CPU/DMA) latches a read winner at t. At t+1 the owner's rvalid=1 and its rdata=mem_rdata. A non-owner's rdata=0.
- Writes produce no rvalid.
- cpu_stall = cpu_req AND the CPU did not win in t. The CPU holds its request; it is served in a later cycle.
- FSM state ARB:
  - Winner priority: (1) DMA if dma_req and wait_cnt==MAX_WAIT; (2) CPU if cpu_req; (3) DMA if dma_req.
  - DMA wins with dma_lock=1 -> go to BURST, burst_cnt=1.
- FSM state BURST:
  - DMA owns the port: dma_gnt=dma_req, CPU is always denied.
  - burst_cnt increments on each grant.
  - Exit to ARB when dma_lock=0, or dma_req=0, or burst_cnt==MAX_BURST after a grant.
  - On the MAX_BURST exit, the next ARB cycle gives the CPU priority even if wait_cnt is saturated, so a locked DMA cannot starve the CPU.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle dma_req=1 and dma_gnt=0.
  - Clears on a grant or when dma_req=0.
- Simultaneous cpu_req and dma_req in ARB with wait_cnt<MAX_WAIT -> CPU wins, dma_gnt=0, wait_cnt+1.
- rst (synchronous): state=ARB, wait_cnt=0, burst_cnt=0, owner=NONE.
  - While rst=1, all outputs are forced to 0, including mem_we. A write presented in the reset cycle is dropped.
  - A read granted in the cycle before rst has its rvalid suppressed.
- Idle requesters: addresses and data are don't-care when req=0.

Optional Feature:
- Macro: DATA_MEM_ARB_PERF_EN.
- Defined:
  - Extra output stall_cycles (32 bits) counts cycles with cpu_stall=1, saturating at all-ones, cleared by rst.
  - Extra output dma_grants (32 bits) counts dma_gnt pulses, with the same saturate/clear rules.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- CPU only, rst released: cpu_req=1, we=1, addr=0x0010, wdata=0x00ABCD -> same cycle: mem_en=1, mem_we=1, mem_addr=0x0010, cpu_stall=0. Next cycle: read of 0x0010 -> cpu_rvalid=1 one cycle later, cpu_rdata=0x00ABCD.
- Contention: cpu_req and dma_req both held high, lock=0, MAX_WAIT=8 -> CPU wins 8 cycles, DMA wins cycle 9 (cpu_stall=1 that cycle only), wait_cnt cleared, CPU wins cycle 10.
- Locked burst: CPU idle, dma_req=dma_lock=1 held for 70 cycles, MAX_BURST=64 -> dma_gnt=1 for 64 cycles. Cycle 65 serves the CPU if cpu_req=1. cpu_stall=1 throughout the burst whenever cpu_req=1.
- Read routing: DMA read at addr 0x0020 in t, CPU read at addr 0x0021 in t+1 -> dma_rvalid in t+1 with RAM word of 0x0020; cpu_rvalid in t+2 with RAM word of 0x0021; no cross-delivery.
- Reset mid-burst: in BURST with cpu_req=1, assert rst one cycle -> that cycle all outputs 0, mem_we=0. The first cycle after rst is in ARB and serves the CPU; pending read rvalid is suppressed.
- With DATA_MEM_ARB_PERF_EN: the contention scenario for 18 cycles -> stall_cycles=2, dma_grants=2.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the MEM stage, the image loader and the data RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface data_mem_arbiter_if #(
  parameter int RW = 24,
  parameter int AW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [RW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [RW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_lock;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [RW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [RW-1:0] dma_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] mem_wdata;
  logic [RW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_lock, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_lock, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// CPU/loader arbiter for the single-port data RAM: CPU priority, DMA anti-starvation, locked bursts.
// Define DATA_MEM_ARB_PERF_EN to add stall/grant performance counters.
module data_mem_arbiter #(
  parameter int RW        = 24,
  parameter int AW        = 16,
  parameter int MAX_WAIT  = 8,
  parameter int MAX_BURST = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  data_mem_arbiter_if.slave     bus
`ifdef DATA_MEM_ARB_PERF_EN
  ,
  output logic [31:0]           o_stall_cycles,
  output logic [31:0]           o_dma_grants
`endif
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] WAIT_SAT   = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST);

  typedef enum logic       {ARB, BURST} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

  state_t        r_state;
  owner_t        r_owner;
  logic [WW-1:0] r_wait_cnt;
  logic [BW-1:0] r_burst_cnt;
  logic          r_cpu_prio;

  logic          w_dma_force;
  logic          w_cpu_win;
  logic          w_dma_win;
  logic [BW-1:0] w_burst_nxt;

  // Grants are suppressed during reset so nothing reaches the RAM that cycle.
  always_comb begin
    w_dma_force = bus.dma_req && (r_wait_cnt == WAIT_SAT) && !r_cpu_prio;
    w_cpu_win   = !i_rst && (r_state == ARB) && bus.cpu_req && !w_dma_force;
    w_dma_win   = !i_rst && bus.dma_req && !w_cpu_win;
    w_burst_nxt = r_burst_cnt + 1'b1;
  end

  always_comb begin
    bus.mem_en    = w_cpu_win || w_dma_win;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (w_cpu_win) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (w_dma_win) begin
      bus.mem_we    = bus.dma_we;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end
  end

  always_comb begin
    bus.cpu_stall  = !i_rst && bus.cpu_req && !w_cpu_win;
    bus.dma_gnt    = w_dma_win;
    bus.cpu_rvalid = !i_rst && (r_owner == OWN_CPU);
    bus.dma_rvalid = !i_rst && (r_owner == OWN_DMA);
    bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
    bus.dma_rdata  = bus.dma_rvalid ? bus.mem_rdata : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ARB;
      r_owner     <= OWN_NONE;
      r_wait_cnt  <= '0;
      r_burst_cnt <= '0;
      r_cpu_prio  <= 1'b0;
    end else begin
      if (w_cpu_win && !bus.cpu_we)      r_owner <= OWN_CPU;
      else if (w_dma_win && !bus.dma_we) r_owner <= OWN_DMA;
      else                               r_owner <= OWN_NONE;

      if (!bus.dma_req || w_dma_win)     r_wait_cnt <= '0;
      else if (r_wait_cnt != WAIT_SAT)   r_wait_cnt <= r_wait_cnt + 1'b1;

      case (r_state)
        ARB: begin
          r_cpu_prio <= 1'b0;
          if (w_dma_win && bus.dma_lock) begin
            r_state     <= BURST;
            r_burst_cnt <= BW'(1);
          end
        end
        BURST: begin
          if (!w_dma_win || !bus.dma_lock) begin
            r_state     <= ARB;
            r_burst_cnt <= '0;
          end else if (w_burst_nxt == BURST_LAST) begin
            // Hand the next ARB cycle to the CPU regardless of DMA starvation.
            r_state     <= ARB;
            r_burst_cnt <= '0;
            r_cpu_prio  <= 1'b1;
          end else begin
            r_burst_cnt <= w_burst_nxt;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

`ifdef DATA_MEM_ARB_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_dma_grants;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
      r_dma_grants   <= '0;
    end else begin
      if (bus.cpu_stall && !(&r_stall_cycles)) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (bus.dma_gnt && !(&r_dma_grants))     r_dma_grants   <= r_dma_grants + 1'b1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_dma_grants   = r_dma_grants;
`endif
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small 1-cycle-latency RAM model.
module tb_data_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.RW(24), .AW(16)) bus ();

`ifdef DATA_MEM_ARB_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] dma_grants;
`endif

  data_mem_arbiter #(.RW(24), .AW(16), .MAX_WAIT(8), .MAX_BURST(64)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef DATA_MEM_ARB_PERF_EN
    ,
    .o_stall_cycles (stall_cycles),
    .o_dma_grants   (dma_grants)
`endif
  );

  logic [23:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end
  end

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic req, input logic we, input logic [15:0] a, input logic [23:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic dma(input logic req, input logic lock, input logic we, input logic [15:0] a,
                     input logic [23:0] d);
    bus.dma_req = req; bus.dma_lock = lock; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  initial begin
    bus.mem_rdata = '0;
    cpu(1'b1, 1'b1, 16'h0010, 24'h00ABCD);
    dma(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
    rst = 1'b1;
    cyc(); cyc();
    #2;
    chk("rst_mem_en",  32'(bus.mem_en),    32'd0);
    chk("rst_mem_we",  32'(bus.mem_we),    32'd0);
    chk("rst_stall",   32'(bus.cpu_stall), 32'd0);
    chk("rst_gnt",     32'(bus.dma_gnt),   32'd0);

    // CPU write then read-back
    rst = 1'b0;
    #1;
    chk("wr_mem_en",   32'(bus.mem_en),    32'd1);
    chk("wr_mem_we",   32'(bus.mem_we),    32'd1);
    chk("wr_mem_addr", 32'(bus.mem_addr),  32'h0010);
    chk("wr_stall",    32'(bus.cpu_stall), 32'd0);
    cyc();
    cpu(1'b1, 1'b0, 16'h0010, 24'h0);
    #2;
    chk("rd_mem_en",   32'(bus.mem_en),    32'd1);
    chk("rd_mem_we",   32'(bus.mem_we),    32'd0);
    cyc();
    cpu(1'b0, 1'b0, 16'h0, 24'h0);
    #2;
    chk("rd_rvalid",   32'(bus.cpu_rvalid), 32'd1);
    chk("rd_rdata",    32'(bus.cpu_rdata),  32'h00ABCD);
    chk("rd_dma_rv",   32'(bus.dma_rvalid), 32'd0);
    cyc();

    // Contention: DMA forced through on cycles 9 and 18
    cpu(1'b1, 1'b1, 16'h0030, 24'h000001);
    dma(1'b1, 1'b0, 1'b1, 16'h0040, 24'h000002);
    for (int i = 1; i <= 18; i++) begin
      #2;
      chk($sformatf("cont_gnt_%0d", i),   32'(bus.dma_gnt),   32'((i == 9) || (i == 18)));
      chk($sformatf("cont_stall_%0d", i), 32'(bus.cpu_stall), 32'((i == 9) || (i == 18)));
      chk($sformatf("cont_addr_%0d", i),  32'(bus.mem_addr),
          ((i == 9) || (i == 18)) ? 32'h0040 : 32'h0030);
      cyc();
    end
`ifdef DATA_MEM_ARB_PERF_EN
    chk("perf_stall",  stall_cycles, 32'd2);
    chk("perf_grants", dma_grants,   32'd2);
`endif
    cpu(1'b0, 1'b0, 16'h0, 24'h0);
    dma(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
    cyc();

    // Read routing: DMA read at t, CPU read at t+1
    dma(1'b1, 1'b0, 1'b1, 16'h0020, 24'h111111);
    cyc();
    dma(1'b1, 1'b0, 1'b1, 16'h0021, 24'h222222);
    cyc();
    dma(1'b1, 1'b0, 1'b0, 16'h0020, 24'h0);
    #2;
    chk("route_gnt", 32'(bus.dma_gnt), 32'd1);
    cyc();
    dma(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
    cpu(1'b1, 1'b0, 16'h0021, 24'h0);
    #2;
    chk("route_dma_rv",  32'(bus.dma_rvalid), 32'd1);
    chk("route_dma_rd",  32'(bus.dma_rdata),  32'h111111);
    chk("route_cpu_rv0", 32'(bus.cpu_rvalid), 32'd0);
    chk("route_cpu_rd0", 32'(bus.cpu_rdata),  32'd0);
    chk("route_stall",   32'(bus.cpu_stall),  32'd0);
    cyc();
    cpu(1'b0, 1'b0, 16'h0, 24'h0);
    #2;
    chk("route_cpu_rv",  32'(bus.cpu_rvalid), 32'd1);
    chk("route_cpu_rd",  32'(bus.cpu_rdata),  32'h222222);
    chk("route_dma_rv0", 32'(bus.dma_rvalid), 32'd0);
    chk("route_dma_rd0", 32'(bus.dma_rdata),  32'd0);
    cyc();

    // Locked burst: 64 grants, then the CPU gets cycle 65
    for (int i = 1; i <= 70; i++) begin
      cpu(i >= 10, 1'b1, 16'h0060, 24'h000003);
      dma(1'b1, 1'b1, 1'b1, 16'h0050, 24'h000004);
      #2;
      chk($sformatf("burst_gnt_%0d", i),   32'(bus.dma_gnt),   32'(i <= 64));
      chk($sformatf("burst_stall_%0d", i), 32'(bus.cpu_stall), 32'((i >= 10) && (i <= 64)));
      if (i == 65) chk("burst_cpu_addr", 32'(bus.mem_addr), 32'h0060);
      cyc();
    end
    cpu(1'b0, 1'b0, 16'h0, 24'h0);
    dma(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
    cyc();

    // Reset mid-burst with a DMA read pending
    for (int i = 1; i <= 3; i++) begin
      dma(1'b1, 1'b1, 1'b0, 16'h0020, 24'h0);
      #2;
      chk($sformatf("mb_gnt_%0d", i), 32'(bus.dma_gnt), 32'd1);
      cyc();
    end
    cpu(1'b1, 1'b0, 16'h0021, 24'h0);
    #2;
    chk("mb_stall", 32'(bus.cpu_stall), 32'd1);
    chk("mb_gnt_4", 32'(bus.dma_gnt),   32'd1);
    cyc();
    rst = 1'b1;
    dma(1'b1, 1'b1, 1'b1, 16'h0021, 24'h00DEAD);
    #2;
    chk("mbr_mem_en",  32'(bus.mem_en),     32'd0);
    chk("mbr_mem_we",  32'(bus.mem_we),     32'd0);
    chk("mbr_gnt",     32'(bus.dma_gnt),    32'd0);
    chk("mbr_stall",   32'(bus.cpu_stall),  32'd0);
    chk("mbr_dma_rv",  32'(bus.dma_rvalid), 32'd0);
    chk("mbr_cpu_rv",  32'(bus.cpu_rvalid), 32'd0);
    chk("mbr_dma_rd",  32'(bus.dma_rdata),  32'd0);
    cyc();
    rst = 1'b0;
    dma(1'b1, 1'b1, 1'b0, 16'h0020, 24'h0);
    #2;
    chk("post_stall",  32'(bus.cpu_stall),  32'd0);
    chk("post_gnt",    32'(bus.dma_gnt),    32'd0);
    chk("post_addr",   32'(bus.mem_addr),   32'h0021);
    chk("post_dma_rv", 32'(bus.dma_rvalid), 32'd0);
    cyc();
    cpu(1'b0, 1'b0, 16'h0, 24'h0);
    dma(1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
    #2;
    chk("post_cpu_rv", 32'(bus.cpu_rvalid), 32'd1);
    chk("post_cpu_rd", 32'(bus.cpu_rdata),  32'h222222);
`ifdef DATA_MEM_ARB_PERF_EN
    chk("perf_clr_stall",  stall_cycles, 32'd0);
    chk("perf_clr_grants", dma_grants,   32'd0);
`endif
    cyc();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
